// File: rtl/systolic_pkg.sv
// Shared types and default sizing for the systolic MAC array and its feeders.
package systolic_pkg;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DRAIN
  } feeder_state_t;

  localparam int unsigned ARRAY_N = 4;
  localparam int unsigned DATA_W  = 8;

  // Width of a counter that must hold the values 0..n-1.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/skew_line.sv
// Fixed-depth data/valid shift line: one lane's delay in the skew feeder.
module skew_line #(
  parameter int unsigned DEPTH  = 1,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic [DATA_W-1:0] d_i,
  input  logic              v_i,
  output logic [DATA_W-1:0] q_o,
  output logic              v_o
);

  logic [DATA_W-1:0] r_data [DEPTH];
  logic [DEPTH-1:0]  r_vld;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_data[i] <= '0;
      end
      r_vld <= '0;
    end else begin
      r_data[0] <= d_i;
      r_vld[0]  <= v_i;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        r_data[i] <= r_data[i-1];
        r_vld[i]  <= r_vld[i-1];
      end
    end
  end

  assign q_o = r_data[DEPTH-1];
  assign v_o = r_vld[DEPTH-1];

endmodule

// File: rtl/systolic_skew_feeder.sv
// West-edge feeder: skews lane i by i cycles and appends an N-cycle zero drain per tile.
module systolic_skew_feeder
  import systolic_pkg::feeder_state_t, systolic_pkg::IDLE, systolic_pkg::STREAM,
         systolic_pkg::DRAIN;
#(
  parameter int unsigned N      = systolic_pkg::ARRAY_N,
  parameter int unsigned DATA_W = systolic_pkg::DATA_W
) (
  input  logic                clock_i,
  input  logic                reset_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [N*DATA_W-1:0] in_data_i,
  input  logic                in_last_i,
  output logic [N*DATA_W-1:0] a_o,
  output logic [N-1:0]        a_valid_o,
  output logic                busy_o,
  output logic                tile_done_o
);

  localparam int unsigned CntW = systolic_pkg::cnt_width(N);

  feeder_state_t r_state;
  feeder_state_t w_state_d;
  logic [CntW-1:0] r_cnt;
  logic [CntW-1:0] w_cnt_d;

  logic w_in_ready;
  logic w_accept;
  logic w_busy;
  logic w_tile_done;

  // Readiness depends on state only, so accept never loops back through the FSM decode.
  assign w_in_ready = (r_state != DRAIN);
  assign w_accept   = in_valid_i && w_in_ready;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
    end
  end

  always_comb begin
    w_state_d   = r_state;
    w_cnt_d     = r_cnt;
    w_busy      = 1'b0;
    w_tile_done = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_d = in_last_i ? DRAIN : STREAM;
          w_cnt_d   = '0;
        end
      end
      STREAM: begin
        w_busy = 1'b1;
        if (w_accept && in_last_i) begin
          w_state_d = DRAIN;
          w_cnt_d   = '0;
        end
      end
      DRAIN: begin
        w_busy = 1'b1;
        // N drain cycles cover the deepest lane (N registers).
        if (r_cnt == CntW'(N - 1)) begin
          w_state_d   = IDLE;
          w_cnt_d     = '0;
          w_tile_done = 1'b1;
        end else begin
          w_cnt_d = r_cnt + CntW'(1);
        end
      end
      default: begin
        w_state_d = IDLE;
        w_cnt_d   = '0;
      end
    endcase
  end

  assign in_ready_o  = w_in_ready;
  assign busy_o      = w_busy;
  assign tile_done_o = w_tile_done;

  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [DATA_W-1:0] w_lane_d;

    // Non-accepted cycles inject a zero bubble so the skew keeps advancing.
    assign w_lane_d = w_accept ? in_data_i[i*DATA_W +: DATA_W] : '0;

    skew_line #(
      .DEPTH (i + 1),
      .DATA_W(DATA_W)
    ) u_skew_line (
      .clock_i(clock_i),
      .reset_i(reset_i),
      .d_i    (w_lane_d),
      .v_i    (w_accept),
      .q_o    (a_o[i*DATA_W +: DATA_W]),
      .v_o    (a_valid_o[i])
    );
  end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Self-checking bench for systolic_skew_feeder: per-cycle model compare plus literal spot checks.
module tb_systolic_skew_feeder;

  localparam int N = 4;
  localparam int W = 8;

  logic           clock_i = 1'b0;
  logic           reset_i;
  logic           in_valid_i;
  logic           in_ready_o;
  logic [N*W-1:0] in_data_i;
  logic           in_last_i;
  logic [N*W-1:0] a_o;
  logic [N-1:0]   a_valid_o;
  logic           busy_o;
  logic           tile_done_o;

  int total = 0;
  int bad   = 0;

  systolic_skew_feeder #(
    .N     (N),
    .DATA_W(W)
  ) dut (
    .clock_i    (clock_i),
    .reset_i    (reset_i),
    .in_valid_i (in_valid_i),
    .in_ready_o (in_ready_o),
    .in_data_i  (in_data_i),
    .in_last_i  (in_last_i),
    .a_o        (a_o),
    .a_valid_o  (a_valid_o),
    .busy_o     (busy_o),
    .tile_done_o(tile_done_o)
  );

  always #5 clock_i = ~clock_i;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%h want=%h", name, $time, got, exp);
    end
  endtask

  // Model: what was fed into the skew at the edge ending each cycle, plus tile timing.
  logic [N*W-1:0] fed_d [256];
  bit             fed_v [256];
  int  cyc       = 1;      // cycle 0 is the time-0 reset cycle
  int  last_rst  = 0;
  int  last_beat = -1000;
  bit  in_tile   = 0;
  logic [N*W-1:0] ea;
  logic [N-1:0]   ev;
  bit  er, eb, ed, acc;

  initial begin
    for (int k = 0; k < 256; k++) begin
      fed_d[k] = '0;
      fed_v[k] = 1'b0;
    end
  end

  always @(negedge clock_i) begin
    ea = '0;
    ev = '0;
    for (int i = 0; i < N; i++) begin
      int src;
      src = cyc - 1 - i;
      if (src > last_rst) begin
        ev[i]           = fed_v[src % 256];
        ea[i*W +: W]    = fed_d[src % 256][i*W +: W];
      end
    end
    er = !(cyc > last_beat && cyc <= last_beat + N);
    ed = (cyc == last_beat + N);
    eb = in_tile || !er;
    chk("a_o", 64'(a_o), 64'(ea));
    chk("a_valid_o", 64'(a_valid_o), 64'(ev));
    chk("in_ready_o", 64'(in_ready_o), 64'(er));
    chk("busy_o", 64'(busy_o), 64'(eb));
    chk("tile_done_o", 64'(tile_done_o), 64'(ed));

    acc = in_valid_i && er && !reset_i;
    fed_v[cyc % 256] = acc;
    fed_d[cyc % 256] = acc ? in_data_i : '0;
    if (reset_i) begin
      last_rst  = cyc;
      last_beat = -1000;
      in_tile   = 0;
    end else if (acc) begin
      if (in_last_i) begin
        last_beat = cyc;
        in_tile   = 0;
      end else begin
        in_tile = 1;
      end
    end
    cyc++;
  end

  // Drive one cycle's inputs just after the rising edge, then settle at the falling edge.
  task automatic step(input bit v, input logic [N*W-1:0] d, input bit l, input bit r);
    @(posedge clock_i);
    #1;
    in_valid_i = v;
    in_data_i  = d;
    in_last_i  = l;
    reset_i    = r;
    @(negedge clock_i);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    reset_i    = 1'b1;
    in_valid_i = 1'b1;
    in_data_i  = '1;
    in_last_i  = 1'b0;

    // Reset held 3 cycles with valid asserted
    step(1'b1, '1, 1'b0, 1'b1);
    chk("rst_busy", 64'(busy_o), 64'd0);
    step(1'b1, '1, 1'b0, 1'b1);
    chk("rst_avalid", 64'(a_valid_o), 64'd0);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("rst_ready_after", 64'(in_ready_o), 64'd1);
    chk("rst_a_o", 64'(a_o), 64'd0);
    idle(2);

    // Single-beat tile
    step(1'b1, 32'h04030201, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("sb_lane0", 64'(a_o[7:0]), 64'h01);
    chk("sb_v_t1", 64'(a_valid_o), 64'b0001);
    chk("sb_ready_t1", 64'(in_ready_o), 64'd0);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("sb_lane1", 64'(a_o[15:8]), 64'h02);
    chk("sb_v_t2", 64'(a_valid_o), 64'b0010);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("sb_lane2", 64'(a_o[23:16]), 64'h03);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("sb_lane3", 64'(a_o[31:24]), 64'h04);
    chk("sb_v_t4", 64'(a_valid_o), 64'b1000);
    chk("sb_done_t4", 64'(tile_done_o), 64'd1);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("sb_busy_t5", 64'(busy_o), 64'd0);
    chk("sb_v_t5", 64'(a_valid_o), 64'd0);
    idle(1);

    // Three back-to-back beats
    step(1'b1, 32'h13121110, 1'b0, 1'b0);
    step(1'b1, 32'h23222120, 1'b0, 1'b0);
    step(1'b1, 32'h33323130, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("st_lane0", 64'(a_o[7:0]), 64'h30);
    chk("st_v_t1", 64'(a_valid_o), 64'b0111);
    chk("st_lane2", 64'(a_o[23:16]), 64'h12);
    idle(3);
    chk("st_lane3", 64'(a_o[31:24]), 64'h33);
    chk("st_done", 64'(tile_done_o), 64'd1);
    chk("st_ready_t4", 64'(in_ready_o), 64'd0);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("st_ready_t5", 64'(in_ready_o), 64'd1);

    // Bubble between two beats
    step(1'b1, 32'h44434241, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b1, 32'h54535251, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("bb_v_t3", 64'(a_valid_o), 64'b0101);
    chk("bb_lane2_t3", 64'(a_o[23:16]), 64'h43);
    chk("bb_lane1_t3", 64'(a_o[15:8]), 64'h00);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("bb_v_t4", 64'(a_valid_o), 64'b1010);
    chk("bb_lane1_t4", 64'(a_o[15:8]), 64'h52);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("bb_v_t5", 64'(a_valid_o), 64'b0100);
    chk("bb_lane2_t5", 64'(a_o[23:16]), 64'h53);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("bb_lane3_t6", 64'(a_o[31:24]), 64'h54);
    chk("bb_done_t6", 64'(tile_done_o), 64'd1);
    idle(1);

    // Valid held through drain is not accepted until back in IDLE
    step(1'b1, 32'h64636261, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) step(1'b1, 32'hAAAAAAAA, 1'b1, 1'b0);
    step(1'b1, 32'hAAAAAAAA, 1'b1, 1'b0);
    chk("dv_ready_t5", 64'(in_ready_o), 64'd1);
    chk("dv_v_t5", 64'(a_valid_o), 64'd0);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("dv_lane0", 64'(a_o[7:0]), 64'hAA);
    chk("dv_v_t6", 64'(a_valid_o), 64'b0001);
    idle(5);

    // Reset two cycles after the first beat of a tile
    step(1'b1, 32'h74737271, 1'b0, 1'b0);
    step(1'b1, 32'h84838281, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1);
    chk("mr_busy_pre", 64'(busy_o), 64'd1);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("mr_a_o", 64'(a_o), 64'd0);
    chk("mr_v", 64'(a_valid_o), 64'd0);
    chk("mr_busy", 64'(busy_o), 64'd0);
    chk("mr_ready", 64'(in_ready_o), 64'd1);
    idle(6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
